// File: rtl/parsed_msg_fifo_if.sv
// ---------------------------------------------------------------------------
// parsed_msg_fifo_if
// Purpose : bundles the producer-side message fields, the consumer-side head
//           entry handshake and the status outputs of parsed_msg_fifo.
// Ports   :
//   parsed_valid, parsed_type, order_ref, side, shares, price,
//   new_order_ref, timestamp, misc_data      producer -> FIFO (one message)
//   out_ready                                consumer -> FIFO
//   out_valid, out_type, out_order_ref, out_side, out_shares, out_price,
//   out_new_order_ref, out_timestamp, out_misc_data   FIFO -> consumer (head)
//   fifo_count, overflow, drop_count         FIFO status
// Modports: master = producer/consumer side, slave = the FIFO itself.
// ---------------------------------------------------------------------------
interface parsed_msg_fifo_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          parsed_valid;
    logic [3:0]    parsed_type;
    logic [63:0]   order_ref;
    logic          side;
    logic [31:0]   shares;
    logic [31:0]   price;
    logic [63:0]   new_order_ref;
    logic [47:0]   timestamp;
    logic [63:0]   misc_data;

    logic          out_ready;
    logic          out_valid;
    logic [3:0]    out_type;
    logic [63:0]   out_order_ref;
    logic          out_side;
    logic [31:0]   out_shares;
    logic [31:0]   out_price;
    logic [63:0]   out_new_order_ref;
    logic [47:0]   out_timestamp;
    logic [63:0]   out_misc_data;

    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic [15:0]   drop_count;

    modport master (
        output parsed_valid, parsed_type, order_ref, side, shares, price,
               new_order_ref, timestamp, misc_data, out_ready,
        input  out_valid, out_type, out_order_ref, out_side, out_shares,
               out_price, out_new_order_ref, out_timestamp, out_misc_data,
               fifo_count, overflow, drop_count
    );

    modport slave (
        input  parsed_valid, parsed_type, order_ref, side, shares, price,
               new_order_ref, timestamp, misc_data, out_ready,
        output out_valid, out_type, out_order_ref, out_side, out_shares,
               out_price, out_new_order_ref, out_timestamp, out_misc_data,
               fifo_count, overflow, drop_count
    );
endinterface

// File: rtl/parsed_msg_fifo.sv
// ---------------------------------------------------------------------------
// parsed_msg_fifo
// Purpose : show-ahead FIFO of fully parsed market messages (309-bit entries).
//           Messages arriving while full are dropped unless a pop frees a slot
//           in the same cycle; a sticky overflow flag records any drop.
// Ports   :
//   clk  - single clock, all state on posedge
//   rst  - synchronous active-high reset
//   bus  - parsed_msg_fifo_if.slave (message in, head entry out, status)
// Options : define PARSED_FIFO_DROP_STATS_EN to build a saturating 16-bit
//           dropped-message counter on drop_count; otherwise it reads 0.
// DEPTH must be a power of two in 2..64 so the pointers wrap by overflow.
// ---------------------------------------------------------------------------
module parsed_msg_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    parsed_msg_fifo_if.slave     bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 309;

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic          full;
    logic          not_empty;
    logic          pop;
    logic          push;
    logic          drop;
    logic [EW-1:0] entry_in;
    logic [EW-1:0] head;

    assign full      = (count_q == CW'(DEPTH));
    assign not_empty = (count_q != '0);
    assign pop       = not_empty & bus.out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = bus.parsed_valid & (~full | pop);
    assign drop      = bus.parsed_valid & full & ~pop;

    assign entry_in = {bus.parsed_type, bus.order_ref, bus.side, bus.shares,
                       bus.price, bus.new_order_ref, bus.timestamp,
                       bus.misc_data};

    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; it maps onto plain
    // RAM, and the head is masked to zero below whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= entry_in;
    end

    assign head = not_empty ? mem_q[rd_ptr_q] : '0;

    assign bus.out_valid = not_empty;
    assign {bus.out_type, bus.out_order_ref, bus.out_side, bus.out_shares,
            bus.out_price, bus.out_new_order_ref, bus.out_timestamp,
            bus.out_misc_data} = head;
    assign bus.fifo_count = count_q;
    assign bus.overflow   = overflow_q;

`ifdef PARSED_FIFO_DROP_STATS_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturates so a long overload never wraps back to a small count.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign bus.drop_count = drop_cnt_q;
`else
    assign bus.drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_parsed_msg_fifo.sv
// ---------------------------------------------------------------------------
// tb_parsed_msg_fifo
// Purpose : directed, table-driven check of parsed_msg_fifo (DEPTH = 8),
//           plus hand-written sequences for the specific-message hold and the
//           continuous pass-through corner cases.
// ---------------------------------------------------------------------------
module tb_parsed_msg_fifo;
    localparam int DEPTH = 8;
`ifdef PARSED_FIFO_DROP_STATS_EN
    localparam int DU = 1;
`else
    localparam int DU = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    parsed_msg_fifo_if #(.DEPTH(DEPTH)) bus ();

    parsed_msg_fifo #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       r;
        logic       pv;
        logic       rdy;
        logic [7:0] tag;
        logic       ev;
        int         ec;
        logic [7:0] eh;
        logic       eo;
        int         ed;
    } vec_t;

    vec_t vecs[$];
    int   n_chk = 0;
    int   n_bad = 0;

    function automatic logic [308:0] make_msg(input logic [7:0] tag);
        return {tag[3:0], {8{tag}} ^ 64'hA5A5_0F0F_3C3C_9696, tag[0],
                32'd1000 + {24'd0, tag}, {tag, 24'h123456}, ~{8{tag}},
                {6{tag}}, {tag, 56'hDE_ADBE_EFCA_FE00}};
    endfunction

    function automatic logic [308:0] head_bits();
        return {bus.out_type, bus.out_order_ref, bus.out_side, bus.out_shares,
                bus.out_price, bus.out_new_order_ref, bus.out_timestamp,
                bus.out_misc_data};
    endfunction

    function automatic void add(input logic r, input logic pv, input logic rdy,
                                input logic [7:0] tag, input logic ev,
                                input int ec, input logic [7:0] eh,
                                input logic eo, input int ed);
        vecs.push_back('{r, pv, rdy, tag, ev, ec, eh, eo, ed});
    endfunction

    task automatic check(input string name, input logic [308:0] act,
                         input logic [308:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the
    // rising edge that consumed them.
    task automatic step(input logic r, input logic pv, input logic rdy,
                        input logic [308:0] m);
        @(negedge clk);
        rst              = r;
        bus.parsed_valid = pv;
        bus.out_ready    = rdy;
        {bus.parsed_type, bus.order_ref, bus.side, bus.shares, bus.price,
         bus.new_order_ref, bus.timestamp, bus.misc_data} = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [308:0] m;
        rst              = 1'b1;
        bus.parsed_valid = 1'b0;
        bus.out_ready    = 1'b0;
        {bus.parsed_type, bus.order_ref, bus.side, bus.shares, bus.price,
         bus.new_order_ref, bus.timestamp, bus.misc_data} = '0;

        // ---- vector table: r pv rdy tag | valid count head ovf drops ----
        add(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0);       // reset state
        add(0, 1, 0, 8'h01, 1, 1, 8'h01, 0, 0);       // push into empty
        add(0, 0, 0, 8'h09, 1, 1, 8'h01, 0, 0);       // held, junk fields
        add(0, 1, 1, 8'h02, 1, 1, 8'h02, 0, 0);       // push+pop
        add(0, 1, 0, 8'h03, 1, 2, 8'h02, 0, 0);       // push only
        add(0, 0, 1, 8'h00, 1, 1, 8'h03, 0, 0);       // pop
        add(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);       // pop to empty
        add(0, 1, 1, 8'h04, 1, 1, 8'h04, 0, 0);       // empty: push, no pop
        add(0, 0, 0, 8'hEE, 1, 1, 8'h04, 0, 0);       // pv=0 ignores fields
        add(0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0);
        for (int k = 0; k < 8; k++)                    // fill 0x10..0x17
            add(0, 1, 0, 8'(16 + k), 1, k + 1, 8'h10, 0, 0);
        for (int k = 0; k < 3; k++)                    // 3 drops while full
            add(0, 1, 0, 8'(32 + k), 1, 8, 8'h10, 1, (k + 1) * DU);
        add(0, 1, 1, 8'h23, 1, 8, 8'h11, 1, 3 * DU);  // full push+pop
        for (int k = 0; k < 6; k++)                    // drain old entries
            add(0, 0, 1, 8'h00, 1, 7 - k, 8'(18 + k), 1, 3 * DU);
        add(0, 0, 1, 8'h00, 1, 1, 8'h23, 1, 3 * DU);  // new msg is last
        add(0, 0, 1, 8'h00, 0, 0, 8'h00, 1, 3 * DU);  // empty, ovf sticky
        for (int k = 0; k < 5; k++)                    // fill to 5
            add(0, 1, 0, 8'(48 + k), 1, k + 1, 8'h30, 1, 3 * DU);
        add(1, 1, 1, 8'h40, 0, 0, 8'h00, 0, 0);       // rst wins
        add(0, 1, 0, 8'h41, 1, 1, 8'h41, 0, 0);       // first push after rst

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].pv, vecs[i].rdy, make_msg(vecs[i].tag));
            check($sformatf("v%0d out_valid", i), 309'(bus.out_valid),
                  309'(vecs[i].ev));
            check($sformatf("v%0d fifo_count", i), 309'(bus.fifo_count),
                  309'(vecs[i].ec));
            check($sformatf("v%0d overflow", i), 309'(bus.overflow),
                  309'(vecs[i].eo));
            check($sformatf("v%0d drop_count", i), 309'(bus.drop_count),
                  309'(vecs[i].ed));
            if (vecs[i].ev)
                check($sformatf("v%0d head", i), head_bits(),
                      make_msg(vecs[i].eh));
            else
                check($sformatf("v%0d head_no_x", i),
                      309'($isunknown(head_bits())), 309'(0));
        end

        // ---- specific message held while out_ready=0 ----
        step(1, 0, 0, '0);
        m = {4'h3, 64'h1122334455667788, 1'b1, 32'd500, 32'd10050,
             64'h0, 48'h0000_1234_5678, 64'hCAFE};
        step(0, 1, 0, m);
        check("spec valid", 309'(bus.out_valid), 309'(1));
        check("spec count", 309'(bus.fifo_count), 309'(1));
        check("spec head", head_bits(), m);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, make_msg(8'(k + 100)));
            check($sformatf("hold%0d head", k), head_bits(), m);
            check($sformatf("hold%0d count", k), 309'(bus.fifo_count), 309'(1));
        end

        // ---- continuous push+pop for 20 cycles: one-cycle pass-through ----
        step(1, 0, 0, '0);
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1, make_msg(8'(k + 128)));
            check($sformatf("stream%0d count", k), 309'(bus.fifo_count),
                  309'(1));
            check($sformatf("stream%0d head", k), head_bits(),
                  make_msg(8'(k + 128)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
        $finish;
    end
endmodule
